// File: rtl/readout_pkt_sink.sv
// Packet sink for the readout-network FIFO: parses HEAD/BODY/TAIL triplets, checks framing and parity,
// and commits good oscillator counts to the result table. Optional cycle timestamp: READOUT_SINK_TIMESTAMP_EN.
module readout_pkt_sink #(
   parameter int NumNode = 32,
   parameter int NumOsc  = 25
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        FifoEmpty_i,
   output logic        FifoRd_o,
   input  logic [31:0] FifoRdData_i,
   output logic        ResWr_o,
   output logic [9:0]  ResAddr_o,
   output logic [23:0] ResData_o,
   output logic [15:0] PktCnt_o,
   output logic [15:0] ErrCnt_o,
   output logic        ErrSticky_o,
   input  logic        ErrClr_i
`ifdef READOUT_SINK_TIMESTAMP_EN
   ,
   output logic [31:0] ResTs_o
`endif
);

   typedef enum logic [1:0] {
      EXP_HEAD,
      EXP_BODY,
      EXP_TAIL,
      RESYNC
   } state_t;

   localparam logic [31:0] NODE_LIM = NumNode;
   localparam logic [31:0] OSC_LIM  = NumOsc;

   state_t      state;
   state_t      state_nxt;
   logic        rd_vld;
   logic [4:0]  id_q;
   logic [4:0]  osc_q;
   logic [23:0] data_q;

   logic        latch_head;
   logic        latch_body;
   logic        commit;
   logic        pkt_err;

   logic [4:0]  word_id;
   logic [4:0]  word_osc;
   logic        is_tail;
   logic        head_ok;
   logic        body_ok;
   logic        tail_ok;
   logic [7:0]  exp_par;

   assign FifoRd_o = ~FifoEmpty_i & rstn;

   assign word_id  = FifoRdData_i[9:5];
   assign word_osc = FifoRdData_i[4:0];
   assign is_tail  = (FifoRdData_i[31:30] == 2'b11);
   assign head_ok  = (FifoRdData_i[31:10] == 22'd0) &&
                     (32'(word_id) < NODE_LIM) && (32'(word_osc) < OSC_LIM);
   assign body_ok  = (FifoRdData_i[31:24] == 8'd0);

   // Upper nibble interleaves data bits by index mod 4, lower nibble covers 6-bit slices
   assign exp_par  = {~^(data_q & 24'h888888), ~^(data_q & 24'h444444),
                      ~^(data_q & 24'h222222), ~^(data_q & 24'h111111),
                      ~^data_q[23:18], ~^data_q[17:12], ~^data_q[11:6], ~^data_q[5:0]};
   assign tail_ok  = is_tail && (FifoRdData_i[29:8] == 22'd0) && (FifoRdData_i[7:0] == exp_par);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state  <= EXP_HEAD;
         rd_vld <= 1'b0;
      end else begin
         state  <= state_nxt;
         rd_vld <= FifoRd_o;
      end
   end

   // A malformed BODY that is itself a TAIL closes the bad packet without passing through RESYNC
   always_comb begin
      state_nxt  = state;
      latch_head = 1'b0;
      latch_body = 1'b0;
      commit     = 1'b0;
      pkt_err    = 1'b0;
      if (rd_vld) begin
         case (state)
            EXP_HEAD: begin
               if (head_ok) begin
                  latch_head = 1'b1;
                  state_nxt  = EXP_BODY;
               end else begin
                  pkt_err   = 1'b1;
                  state_nxt = RESYNC;
               end
            end
            EXP_BODY: begin
               if (body_ok) begin
                  latch_body = 1'b1;
                  state_nxt  = EXP_TAIL;
               end else begin
                  pkt_err   = 1'b1;
                  state_nxt = is_tail ? EXP_HEAD : RESYNC;
               end
            end
            EXP_TAIL: begin
               state_nxt = EXP_HEAD;
               if (tail_ok) begin
                  commit = 1'b1;
               end else begin
                  pkt_err = 1'b1;
               end
            end
            RESYNC: begin
               if (is_tail) begin
                  state_nxt = EXP_HEAD;
               end
            end
            default: state_nxt = EXP_HEAD;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         id_q   <= 5'd0;
         osc_q  <= 5'd0;
         data_q <= 24'd0;
      end else begin
         if (latch_head) begin
            id_q  <= word_id;
            osc_q <= word_osc;
         end
         if (latch_body) begin
            data_q <= FifoRdData_i[23:0];
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ResWr_o   <= 1'b0;
         ResAddr_o <= 10'd0;
         ResData_o <= 24'd0;
      end else begin
         ResWr_o <= commit;
         if (commit) begin
            ResAddr_o <= {id_q, osc_q};
            ResData_o <= data_q;
         end
      end
   end

   // Clear wins over a same-cycle commit or error; that event is simply not counted
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         PktCnt_o    <= 16'd0;
         ErrCnt_o    <= 16'd0;
         ErrSticky_o <= 1'b0;
      end else if (ErrClr_i) begin
         PktCnt_o    <= 16'd0;
         ErrCnt_o    <= 16'd0;
         ErrSticky_o <= 1'b0;
      end else begin
         if (commit && (PktCnt_o != 16'hFFFF)) begin
            PktCnt_o <= PktCnt_o + 16'd1;
         end
         if (pkt_err && (ErrCnt_o != 16'hFFFF)) begin
            ErrCnt_o <= ErrCnt_o + 16'd1;
         end
         if (pkt_err) begin
            ErrSticky_o <= 1'b1;
         end
      end
   end

`ifdef READOUT_SINK_TIMESTAMP_EN
   logic [31:0] ts_cnt;
   logic [31:0] ts_head;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ts_cnt  <= 32'd0;
         ts_head <= 32'd0;
         ResTs_o <= 32'd0;
      end else begin
         ts_cnt <= ts_cnt + 32'd1;
         if (latch_head) begin
            ts_head <= ts_cnt;
         end
         if (commit) begin
            ResTs_o <= ts_head;
         end
      end
   end
`endif

endmodule

// File: tb/tb_readout_pkt_sink.sv
// Bench for readout_pkt_sink: the bench plays the packet FIFO and scores result writes and counters
// against a word-level model of the packet rules. Define READOUT_SINK_TIMESTAMP_EN to cover ResTs_o.
module tb_readout_pkt_sink;

   localparam int NUM_NODE = 32;
   localparam int NUM_OSC  = 25;
   localparam int PH_HEAD  = 0;
   localparam int PH_BODY  = 1;
   localparam int PH_TAIL  = 2;
   localparam int PH_SKIP  = 3;

   typedef struct {
      logic [9:0]  addr;
      logic [23:0] data;
      logic [31:0] ts;
      int          cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        FifoEmpty_i = 1'b1;
   logic        FifoRd_o;
   logic [31:0] FifoRdData_i = 32'd0;
   logic        ResWr_o;
   logic [9:0]  ResAddr_o;
   logic [23:0] ResData_o;
   logic [15:0] PktCnt_o;
   logic [15:0] ErrCnt_o;
   logic        ErrSticky_o;
   logic        ErrClr_i = 1'b0;
`ifdef READOUT_SINK_TIMESTAMP_EN
   logic [31:0] ResTs_o;
`endif

   int          checks = 0;
   int          errors = 0;
   logic [31:0] fifo_q[$];
   exp_t        sb[$];
   int          cyc = 0;
   int          last_pop = -100;
   int          stall_mode = 0;
   logic [31:0] ts_mdl = 32'd0;

   int          m_phase = PH_HEAD;
   logic [9:0]  m_addr = 10'd0;
   logic [23:0] m_data = 24'd0;
   logic [31:0] m_ts = 32'd0;
   int          m_pkt = 0;
   int          m_err = 0;
   logic        m_sticky = 1'b0;

   readout_pkt_sink #(.NumNode(NUM_NODE), .NumOsc(NUM_OSC)) dut (
      .clk          (clk),
      .rstn         (rstn),
      .FifoEmpty_i  (FifoEmpty_i),
      .FifoRd_o     (FifoRd_o),
      .FifoRdData_i (FifoRdData_i),
      .ResWr_o      (ResWr_o),
      .ResAddr_o    (ResAddr_o),
      .ResData_o    (ResData_o),
      .PktCnt_o     (PktCnt_o),
      .ErrCnt_o     (ErrCnt_o),
      .ErrSticky_o  (ErrSticky_o),
      .ErrClr_i     (ErrClr_i)
`ifdef READOUT_SINK_TIMESTAMP_EN
      ,
      .ResTs_o      (ResTs_o)
`endif
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, actual, expected, cyc);
      end
   endtask

   function automatic logic [7:0] makePar(input logic [23:0] d);
      logic [7:0] p;
      logic [3:0] g;
      g = 4'd0;
      for (int i = 0; i < 24; i++) begin
         g[i % 4] = g[i % 4] ^ d[i];
      end
      for (int k = 0; k < 4; k++) begin
         p[4 + k] = ~g[k];
         p[k]     = ~(^d[6 * k +: 6]);
      end
      return p;
   endfunction

   task automatic modelError();
      if (m_err < 65535) m_err++;
      m_sticky = 1'b1;
   endtask

   task automatic modelReset();
      m_phase  = PH_HEAD;
      m_pkt    = 0;
      m_err    = 0;
      m_sticky = 1'b0;
   endtask

   // Word-level packet rules; a commit is expected on ResWr_o one cycle after the pop edge
   task automatic modelWord(input logic [31:0] w, input int p, input logic [31:0] ts);
      case (m_phase)
         PH_HEAD: begin
            if (w[31:10] == 22'd0 && int'(w[9:5]) < NUM_NODE && int'(w[4:0]) < NUM_OSC) begin
               m_addr  = w[9:0];
               m_ts    = ts;
               m_phase = PH_BODY;
            end else begin
               modelError();
               m_phase = PH_SKIP;
            end
         end
         PH_BODY: begin
            if (w[31:24] == 8'd0) begin
               m_data  = w[23:0];
               m_phase = PH_TAIL;
            end else begin
               modelError();
               m_phase = (w[31:30] == 2'b11) ? PH_HEAD : PH_SKIP;
            end
         end
         PH_TAIL: begin
            if (w[31:30] == 2'b11 && w[29:8] == 22'd0 && w[7:0] == makePar(m_data)) begin
               sb.push_back('{m_addr, m_data, m_ts, p + 1});
               if (m_pkt < 65535) m_pkt++;
            end else begin
               modelError();
            end
            m_phase = PH_HEAD;
         end
         default: begin
            if (w[31:30] == 2'b11) m_phase = PH_HEAD;
         end
      endcase
   endtask

   task automatic tick();
      logic        pop_now;
      logic [31:0] w;
      exp_t        e;
      logic        stall;
      #4;
      pop_now = FifoRd_o;
      @(posedge clk);
      cyc++;
      if (rstn) ts_mdl = ts_mdl + 32'd1;
      else ts_mdl = 32'd0;
      #1;
      if (pop_now === 1'b1) begin
         if (fifo_q.size() == 0) begin
            checkOutput("rd_while_empty", 32'(pop_now), 32'd0);
         end else begin
            w = fifo_q.pop_front();
            FifoRdData_i = w;
            last_pop = cyc;
            modelWord(w, cyc, ts_mdl);
         end
      end
      @(negedge clk);
      if (sb.size() != 0 && sb[0].cyc == cyc) begin
         e = sb.pop_front();
         checkOutput("res_wr", 32'(ResWr_o), 32'd1);
         checkOutput("res_addr", 32'(ResAddr_o), 32'(e.addr));
         checkOutput("res_data", 32'(ResData_o), 32'(e.data));
`ifdef READOUT_SINK_TIMESTAMP_EN
         checkOutput("res_ts", ResTs_o, e.ts);
`endif
      end else if (ResWr_o !== 1'b0) begin
         checkOutput("res_wr_spurious", 32'(ResWr_o), 32'd0);
      end
      case (stall_mode)
         1:       stall = ($urandom_range(0, 2) == 0);
         2:       stall = (cyc - last_pop) < 3;
         default: stall = 1'b0;
      endcase
      FifoEmpty_i = (fifo_q.size() == 0) || stall;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((fifo_q.size() != 0 || sb.size() != 0) && n < 4000) begin
         tick();
         n++;
      end
      repeat (4) tick();
      checkOutput("drain_done", 32'(fifo_q.size() + sb.size()), 32'd0);
   endtask

   task automatic checkCounters(input string tag);
      checkOutput({tag, "_pkt_cnt"}, 32'(PktCnt_o), 32'(m_pkt));
      checkOutput({tag, "_err_cnt"}, 32'(ErrCnt_o), 32'(m_err));
      checkOutput({tag, "_sticky"}, 32'(ErrSticky_o), 32'(m_sticky));
   endtask

   task automatic pushPkt(input logic [31:0] head, input logic [31:0] body, input logic [31:0] tail);
      fifo_q.push_back(head);
      fifo_q.push_back(body);
      fifo_q.push_back(tail);
   endtask

   // Kinds: 0 good, 1 bad parity, 2 bad Osc, 3 missing TAIL, 4 bad HEAD reserved,
   // 5 bad BODY upper byte, 6 random word, 7 stray TAIL
   task automatic applyStimulus(input int kind);
      logic [4:0]  id;
      logic [4:0]  osc;
      logic [23:0] d;
      logic [31:0] head;
      logic [31:0] body;
      logic [31:0] tail;
      int          b;
      id   = 5'($urandom_range(0, NUM_NODE - 1));
      osc  = 5'($urandom_range(0, NUM_OSC - 1));
      d    = 24'($urandom);
      head = {22'd0, id, osc};
      body = {8'd0, d};
      tail = {24'hC00000, makePar(d)};
      b    = 0;
      case (kind)
         1: begin
            b = $urandom_range(0, 7);
            tail[b] = ~tail[b];
         end
         2: head[4:0] = 5'($urandom_range(NUM_OSC, 31));
         3: begin
            fifo_q.push_back(head);
            fifo_q.push_back(body);
            return;
         end
         4: begin
            b = 10 + $urandom_range(0, 21);
            head[b] = 1'b1;
         end
         5: begin
            b = 24 + $urandom_range(0, 7);
            body[b] = 1'b1;
         end
         6: begin
            fifo_q.push_back($urandom);
            return;
         end
         7: begin
            fifo_q.push_back(tail);
            return;
         end
         default: ;
      endcase
      pushPkt(head, body, tail);
   endtask

   initial begin
      #1;
      FifoEmpty_i = 1'b0;
      #1;
      checkOutput("rst_fifo_rd", 32'(FifoRd_o), 32'd0);
      checkOutput("rst_res_wr", 32'(ResWr_o), 32'd0);
      checkOutput("rst_res_addr", 32'(ResAddr_o), 32'd0);
      checkOutput("rst_res_data", 32'(ResData_o), 32'd0);
      checkCounters("rst");
      FifoEmpty_i = 1'b1;
      @(negedge clk);
      tick();
      rstn = 1'b1;

      // Reference packet: HEAD 0x123 -> ID 9, Osc 3
      pushPkt(32'h0000_0123, 32'h00AB_CDEF, {24'hC00000, makePar(24'hABCDEF)});
      drain();
      checkOutput("good_addr", 32'(ResAddr_o), {22'd0, 5'd9, 5'd3});
      checkOutput("good_data", 32'(ResData_o), 32'h00AB_CDEF);
      checkOutput("good_pkt_cnt", 32'(PktCnt_o), 32'd1);
      checkCounters("good");

      pushPkt(32'h0000_0123, 32'h00AB_CDEF, {24'hC00000, makePar(24'hABCDEF) ^ 8'h01});
      drain();
      checkOutput("par_err_cnt", 32'(ErrCnt_o), 32'd1);
      checkOutput("par_sticky", 32'(ErrSticky_o), 32'd1);
      applyStimulus(0);
      drain();
      checkOutput("par_then_good_pkt", 32'(PktCnt_o), 32'd2);
      checkCounters("par");

      pushPkt(32'h0000_0045, 32'h0012_3456, 32'h0000_0087);
      pushPkt(32'h0000_0021, 32'h0000_0011, {24'hC00000, makePar(24'h000011)});
      applyStimulus(0);
      drain();
      checkCounters("miss_tail");

      pushPkt({22'd0, 5'd4, 5'd25}, 32'h0000_0777, {24'hC00000, makePar(24'h000777)});
      drain();
      checkCounters("osc_lim");

      ErrClr_i = 1'b1;
      tick();
      ErrClr_i = 1'b0;
      modelReset();
      checkOutput("clr_pkt_cnt", 32'(PktCnt_o), 32'd0);
      checkOutput("clr_err_cnt", 32'(ErrCnt_o), 32'd0);
      checkOutput("clr_sticky", 32'(ErrSticky_o), 32'd0);

      stall_mode = 2;
      for (int i = 0; i < 4; i++) applyStimulus(0);
      drain();
      checkOutput("stall_pkt_cnt", 32'(PktCnt_o), 32'd4);
      checkCounters("stall");
      stall_mode = 0;

      // Reset with a packet half delivered: nothing of it may surface afterwards
      pushPkt(32'h0000_0123, 32'h00AB_CDEF, 32'h0);
      void'(fifo_q.pop_back());
      drain();
      rstn = 1'b0;
      modelReset();
      tick();
      checkOutput("midrst_res_addr", 32'(ResAddr_o), 32'd0);
      checkCounters("midrst");
      tick();
      rstn = 1'b1;
      applyStimulus(0);
      drain();
      checkOutput("midrst_pkt_cnt", 32'(PktCnt_o), 32'd1);
      checkCounters("post_rst");

      stall_mode = 1;
      for (int i = 0; i < 200; i++) begin
         applyStimulus(($urandom_range(0, 1) == 0) ? 0 : $urandom_range(0, 7));
      end
      applyStimulus(7);
      applyStimulus(0);
      drain();
      checkCounters("random");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not complete, checks %0d", checks);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
